// File: rtl/gfsk_tx_pkg.sv
// gfsk_tx_pkg: shared definitions for the GFSK transmit modulator.
//   - gfsk_state_t : modulator FSM states (IDLE, ACTIVE, DRAIN)
//   - QUARTER_SIN  : first-quadrant sine magnitudes for a 16-entry table
//                    (LUT_BITS=4) scaled to A=7 (DATA_WIDTH=4)
//   - WHITEN_*     : BLE x^7+x^4+1 whitening seed/tap constants and step
//                    function, used only when TX_WHITEN_EN is defined.
package gfsk_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } gfsk_state_t;

    localparam int unsigned LUT_DEPTH = 16;

    // round(7 * sin(pi/2 * k/16)), k = 0..15
    localparam logic [7:0] QUARTER_SIN [LUT_DEPTH] = '{
        8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4,
        8'd5, 8'd5, 8'd6, 8'd6, 8'd6, 8'd7, 8'd7, 8'd7
    };

    // Register bit k holds whitening position 6-k: bit 6 is position 0
    // (seeded to 1), bits 5:0 take the channel index MSB-first, and the
    // output is taken from bit 0 (position 6).
    localparam logic       WHITEN_SEED_MSB = 1'b1;
    localparam logic [6:0] WHITEN_TAPS     = 7'b000_0100;

    function automatic logic [6:0] whiten_step(input logic [6:0] s);
        return {s[0], s[6:1]} ^ (s[0] ? WHITEN_TAPS : 7'b0);
    endfunction

endpackage

// File: rtl/gfsk_iq_lut.sv
// gfsk_iq_lut: combinational phase -> signed cos/sin lookup.
//   phase : unsigned phase, full circle = 2^PHASE_WIDTH
//   i_out : signed cosine sample
//   q_out : signed sine sample
// The top two phase bits pick the quadrant, the next LUT_BITS bits index a
// quarter-wave table (bit-inverted in odd quadrants); the remaining low
// phase bits are below table resolution.
module gfsk_iq_lut
    import gfsk_tx_pkg::*;
#(
    parameter int PHASE_WIDTH = 8,
    parameter int DATA_WIDTH  = 4,
    parameter int LUT_BITS    = 4
) (
    input  logic [PHASE_WIDTH-1:0]       phase,
    output logic signed [DATA_WIDTH-1:0] i_out,
    output logic signed [DATA_WIDTH-1:0] q_out
);

    logic [1:0]                   quad;
    logic [LUT_BITS-1:0]          idx;
    logic [LUT_BITS-1:0]          idx_m;
    logic signed [DATA_WIDTH-1:0] mag_d;
    logic signed [DATA_WIDTH-1:0] mag_m;
    logic                         unused_lsbs;

    assign quad        = phase[PHASE_WIDTH-1:PHASE_WIDTH-2];
    assign idx         = phase[PHASE_WIDTH-3 -: LUT_BITS];
    assign idx_m       = ~idx;
    assign mag_d       = DATA_WIDTH'(QUARTER_SIN[idx]);
    assign mag_m       = DATA_WIDTH'(QUARTER_SIN[idx_m]);
    assign unused_lsbs = ^phase[PHASE_WIDTH-3-LUT_BITS:0];

    // cos is sin advanced by one quadrant.
    always_comb begin
        i_out = '0;
        q_out = '0;
        case (quad)
            2'd0: begin i_out =  mag_m; q_out =  mag_d; end
            2'd1: begin i_out = -mag_d; q_out =  mag_m; end
            2'd2: begin i_out = -mag_m; q_out = -mag_d; end
            default: begin i_out = mag_d; q_out = -mag_m; end
        endcase
    end

endmodule

// File: rtl/gfsk_tx_modulator.sv
// gfsk_tx_modulator: BLE GFSK transmit baseband modulator.
// Serial bits arrive on a valid/ready handshake; each bit becomes
// SAMPLE_RATE signed I/Q samples from a slewed-frequency phase accumulator.
// Optional macro TX_WHITEN_EN adds whiten_chan and BLE data whitening.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   en                   : sample strobe, state only advances when high
//   bit_data/valid/last  : upstream bit, its valid, end-of-packet flag
//   bit_ready            : combinational accept
//   whiten_chan          : whitening channel index (TX_WHITEN_EN only)
//   i_data, q_data       : signed cos/sin samples (registered)
//   sample_valid         : one pulse per produced sample
//   symbol_clk           : pulse at sample SAMPLE_POS of each active symbol
//   busy                 : high in ACTIVE and DRAIN
module gfsk_tx_modulator
    import gfsk_tx_pkg::*;
#(
    parameter int SAMPLE_RATE = 16,
    parameter int SAMPLE_POS  = 2,
    parameter int DATA_WIDTH  = 4,
    parameter int PHASE_WIDTH = 8,
    parameter int F_MAX       = 4,
    parameter int F_STEP      = 1,
    parameter int LUT_BITS    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         bit_data,
    input  logic                         bit_valid,
    input  logic                         bit_last,
`ifdef TX_WHITEN_EN
    input  logic [5:0]                   whiten_chan,
`endif
    output logic                         bit_ready,
    output logic signed [DATA_WIDTH-1:0] i_data,
    output logic signed [DATA_WIDTH-1:0] q_data,
    output logic                         sample_valid,
    output logic                         symbol_clk,
    output logic                         busy
);

    localparam int CNT_W = $clog2(SAMPLE_RATE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_SYM  = CNT_W'(SAMPLE_POS);
    localparam logic signed [PHASE_WIDTH-1:0] F_POS  = PHASE_WIDTH'(F_MAX);
    localparam logic signed [PHASE_WIDTH-1:0] F_NEG  = -F_POS;
    localparam logic signed [PHASE_WIDTH-1:0] F_INC  = PHASE_WIDTH'(F_STEP);

    gfsk_state_t                   state;
    logic [CNT_W-1:0]              sample_cnt;
    logic signed [PHASE_WIDTH-1:0] freq;
    logic signed [PHASE_WIDTH-1:0] freq_next;
    logic signed [PHASE_WIDTH-1:0] target;
    logic [PHASE_WIDTH-1:0]        phase;
    logic [PHASE_WIDTH-1:0]        phase_next;
    logic                          last_seen;
    logic                          boundary;
    logic                          transfer;
    logic                          mapped_bit;
    logic signed [DATA_WIDTH-1:0]  lut_i;
    logic signed [DATA_WIDTH-1:0]  lut_q;

    assign boundary = en && (sample_cnt == CNT_LAST);
    assign transfer = bit_valid && bit_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        bit_ready = 1'b0;
        case (state)
            IDLE:    bit_ready = en;
            ACTIVE:  bit_ready = boundary && !last_seen;
            default: bit_ready = 1'b0;
        endcase
    end

    // Move one F_STEP toward target, landing exactly on it.
    always_comb begin
        freq_next = target;
        if (freq < target) begin
            if (target - freq > F_INC) freq_next = freq + F_INC;
        end else if (freq > target) begin
            if (freq - target > F_INC) freq_next = freq - F_INC;
        end
    end

    assign phase_next = phase + freq_next;

`ifdef TX_WHITEN_EN
    logic [6:0] lfsr;
    logic [6:0] lfsr_cur;

    // The first bit of a packet is whitened by the fresh seed directly.
    assign lfsr_cur   = (state == IDLE) ? {WHITEN_SEED_MSB, whiten_chan} : lfsr;
    assign mapped_bit = bit_data ^ lfsr_cur[0];

    always_ff @(posedge clk) begin
        if (reset)         lfsr <= '0;
        else if (transfer) lfsr <= whiten_step(lfsr_cur);
    end
`else
    assign mapped_bit = bit_data;
`endif

    gfsk_iq_lut #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .LUT_BITS    (LUT_BITS)
    ) u_lut (
        .phase (phase_next),
        .i_out (lut_i),
        .q_out (lut_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            freq         <= '0;
            target       <= '0;
            phase        <= '0;
            last_seen    <= 1'b0;
            i_data       <= '0;
            q_data       <= '0;
            sample_valid <= 1'b0;
            symbol_clk   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            symbol_clk   <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: begin
                        i_data <= '0;
                        q_data <= '0;
                        if (transfer) begin
                            target     <= mapped_bit ? F_POS : F_NEG;
                            freq       <= '0;
                            phase      <= '0;
                            sample_cnt <= '0;
                            last_seen  <= bit_last;
                            state      <= ACTIVE;
                        end
                    end
                    ACTIVE, DRAIN: begin
                        freq         <= freq_next;
                        phase        <= phase_next;
                        i_data       <= lut_i;
                        q_data       <= lut_q;
                        sample_valid <= 1'b1;
                        sample_cnt   <= sample_cnt + 1'b1;
                        if (state == ACTIVE) begin
                            symbol_clk <= (sample_cnt == CNT_SYM);
                            if (boundary) begin
                                if (transfer) begin
                                    target    <= mapped_bit ? F_POS : F_NEG;
                                    last_seen <= bit_last;
                                end else begin
                                    target <= '0;
                                    state  <= DRAIN;
                                end
                            end
                        end else if (sample_cnt == CNT_LAST) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gfsk_tx_modulator.sv
`timescale 1ns/1ps
module tb_gfsk_tx_modulator;

    localparam int SR    = 16;
    localparam int SP    = 2;
    localparam int DW    = 4;
    localparam int PW    = 8;
    localparam int FMAX  = 4;
    localparam int FSTEP = 1;
    localparam int AMP   = (1 << (DW - 1)) - 1;
    localparam int CIRC  = 1 << PW;

    logic clk = 1'b0;
    logic reset, en, bit_data, bit_valid, bit_last;
    logic bit_ready, sample_valid, symbol_clk, busy;
    logic signed [DW-1:0] i_data, q_data;
`ifdef TX_WHITEN_EN
    logic [5:0] whiten_chan = 6'd0;
`endif

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    bit     ignore_samples = 1'b0;

    typedef struct {
        int i;
        int q;
        bit sym;
    } samp_t;
    samp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    gfsk_tx_modulator #(
        .SAMPLE_RATE (SR),
        .SAMPLE_POS  (SP),
        .DATA_WIDTH  (DW),
        .PHASE_WIDTH (PW),
        .F_MAX       (FMAX),
        .F_STEP      (FSTEP),
        .LUT_BITS    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .bit_data     (bit_data),
        .bit_valid    (bit_valid),
        .bit_last     (bit_last),
`ifdef TX_WHITEN_EN
        .whiten_chan  (whiten_chan),
`endif
        .bit_ready    (bit_ready),
        .i_data       (i_data),
        .q_data       (q_data),
        .sample_valid (sample_valid),
        .symbol_clk   (symbol_clk),
        .busy         (busy)
    );

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Sine of a phase from quadrant/index rules, amplitude rounded to nearest.
    function automatic int ref_sin(input int ph);
        int  quad = ph / (CIRC / 4);
        int  idx  = (ph % (CIRC / 4)) / 4;
        int  m    = (quad % 2 == 1) ? 15 - idx : idx;
        real mag  = AMP * $sin(3.14159265358979 / 2.0 * m / 16.0);
        int  r    = $rtoi(mag + 0.5);
        return (quad >= 2) ? -r : r;
    endfunction

    function automatic int ref_cos(input int ph);
        return ref_sin((ph + CIRC / 4) % CIRC);
    endfunction

    // Expected samples for a packet of mapped bits: each bit is one symbol,
    // followed by one symbol of slewing back to zero frequency.
    task automatic expect_packet(input bit b[$]);
        int f = 0;
        int ph = 0;
        int tgt;
        int n = b.size();
        for (int s = 0; s <= n; s++) begin
            tgt = (s == n) ? 0 : (b[s] ? FMAX : -FMAX);
            for (int k = 0; k < SR; k++) begin
                if (f < tgt)      f = (f + FSTEP > tgt) ? tgt : f + FSTEP;
                else if (f > tgt) f = (f - FSTEP < tgt) ? tgt : f - FSTEP;
                ph = ((ph + f) % CIRC + CIRC) % CIRC;
                exp_q.push_back('{ref_cos(ph), ref_sin(ph), bit'((s < n) && (k == SP))});
            end
        end
    endtask

    task automatic run_packet(input bit raw[$], input bit underflow, input int duty, input int chan);
        bit     mapped[$];
        bit     taken;
        bit     done;
        int     tries;
        int     en_cnt;
        longint last_t = 0;
`ifdef TX_WHITEN_EN
        bit s[7];
        bit w;
`endif
        mapped = raw;
`ifdef TX_WHITEN_EN
        whiten_chan = chan[5:0];
        s[0] = 1'b1;
        for (int p = 1; p < 7; p++) s[p] = chan[6 - p];
        for (int i = 0; i < raw.size(); i++) begin
            w = s[6];
            mapped[i] = raw[i] ^ w;
            for (int p = 6; p > 0; p--) s[p] = s[p - 1];
            s[0] = w;
            s[4] = s[4] ^ w;
        end
`endif
        expect_packet(mapped);

        for (int i = 0; i < raw.size(); i++) begin
            taken = 1'b0;
            tries = 0;
            while (!taken && tries < 400) begin
                @(negedge clk);
                en        = ($urandom_range(99) < duty);
                bit_valid = 1'b1;
                bit_data  = raw[i];
                bit_last  = (i == raw.size() - 1) && !underflow;
                #1;
                taken = bit_ready;
                tries++;
            end
            if (!taken) begin
                check("handshake_timeout", 0, 1);
                bit_valid = 1'b0;
                return;
            end
            if (duty == 100 && i > 0) check("ready_period", int'(cyc - last_t), SR);
            last_t = cyc;
        end

        // Tail: valid stays low through the next boundary on underflow, then
        // rises to show DRAIN never accepts.
        en_cnt = 0;
        tries  = 0;
        done   = 1'b0;
        while (!done && tries < 2000) begin
            @(negedge clk);
            en        = ($urandom_range(99) < duty);
            bit_valid = underflow && (en_cnt >= SR);
            bit_data  = 1'($urandom_range(1));
            bit_last  = 1'b0;
            #1;
            if (!busy) begin
                bit_valid = 1'b0;
                en        = 1'b1;
                done      = 1'b1;
            end else begin
                if (!underflow || en_cnt >= SR) check("drain_ready", bit_ready, 0);
                en_cnt += int'(en);
                tries++;
            end
        end
        if (!done) begin
            check("busy_timeout", 0, 1);
            return;
        end
        @(posedge clk);
        #1;
        check("idle_i", i_data, 0);
        check("idle_q", q_data, 0);
        check("idle_valid", sample_valid, 0);
    endtask

    task automatic mid_reset();
        ignore_samples = 1'b1;
        @(negedge clk);
        en = 1'b1; bit_valid = 1'b1; bit_data = 1'b1; bit_last = 1'b0;
        #1;
        check("mid_accept_ready", bit_ready, 1);
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", sample_valid, 0);
        check("mid_rst_i", i_data, 0);
        check("mid_rst_q", q_data, 0);
        check("mid_rst_sym", symbol_clk, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        ignore_samples = 1'b0;
    endtask

    // Monitor: pops one expected sample per sample_valid; en-low cycles must
    // hold i/q and produce no strobes.
    initial begin
        int    pi = 0;
        int    pq = 0;
        samp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && !ignore_samples) begin
                if (!en) begin
                    check("enlow_valid", sample_valid, 0);
                    check("enlow_sym", symbol_clk, 0);
                    check("enlow_i_hold", i_data, pi);
                    check("enlow_q_hold", q_data, pq);
                end else if (sample_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_sample", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("i_data", i_data, e.i);
                        check("q_data", q_data, e.q);
                        check("symbol_clk", symbol_clk, int'(e.sym));
                    end
                end else begin
                    check("sym_without_sample", symbol_clk, 0);
                end
            end
            pi = i_data;
            pq = q_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit raw[$];
        int n;
        reset = 1'b1; en = 1'b1; bit_valid = 1'b0; bit_data = 1'b0; bit_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_i", i_data, 0);
        check("rst_q", q_data, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_sym", symbol_clk, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bit_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        raw = '{1'b1};
        run_packet(raw, 1'b0, 100, 5);
        raw = '{1'b1, 1'b0, 1'b1, 1'b0};
        run_packet(raw, 1'b0, 100, 11);
        raw = '{1'b1};
        run_packet(raw, 1'b0, 50, 5);
        raw = '{1'b0, 1'b1};
        run_packet(raw, 1'b1, 100, 20);

        raw.delete();
        for (int i = 0; i < 40; i++) raw.push_back(1'b0);
        run_packet(raw, 1'b0, 100, 37);

        mid_reset();
        repeat (3) @(negedge clk);

        for (int p = 0; p < 12; p++) begin
            raw.delete();
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) raw.push_back(1'($urandom_range(1)));
            run_packet(raw, 1'($urandom_range(1)),
                       (p % 3 == 0) ? 100 : ((p % 3 == 1) ? 50 : 30),
                       $urandom_range(39));
        end

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
